// File: rtl/systolic_tile_ctrl.sv
// systolic_tile_ctrl: tiled-GEMM sequencer for the systolic datapath.
// Computes C[MxN] = A[MxK] * W[KxN] by walking output tiles of ARRAY_N x ARRAY_M,
// row tile outer and column tile inner. Each tile runs CLEAR(1), STREAM(K),
// SKEW(ARRAY_N+ARRAY_M-2), DRAIN(rows) and NEXT(1). A job ends with a single DONE cycle.
// Ports:
//   clk, reset (async, active-low)        clock / reset
//   start, abort                          job request (IDLE only) / synchronous abort
//   mode_in, M, K, N, a_base/w_base/o_base job parameters, latched at start
//   busy, done, err                       job status; done/err are 1-cycle pulses
//   a_buf_on, w_buf_on                    A/W buffer read enables
//   a_base_addr/a_num_rows, w_base_addr/w_num_cols   current tile geometry
//   mode, operation_signal_out            latched mode, array op code
//   o_idx_gen_on, o_ag_o_on, o_drain, o_base_addr    O-buffer controls
module systolic_tile_ctrl #(
  parameter int unsigned ARRAY_N    = 8,
  parameter int unsigned ARRAY_M    = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DIM_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      mode_in,
  input  logic [DIM_WIDTH-1:0]      M,
  input  logic [DIM_WIDTH-1:0]      K,
  input  logic [DIM_WIDTH-1:0]      N,
  input  logic [ADDR_WIDTH-1:0]     a_base,
  input  logic [ADDR_WIDTH-1:0]     w_base,
  input  logic [ADDR_WIDTH-1:0]     o_base,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      a_buf_on,
  output logic                      w_buf_on,
  output logic [ADDR_WIDTH-1:0]     a_base_addr,
  output logic [$clog2(ARRAY_N):0]  a_num_rows,
  output logic [ADDR_WIDTH-1:0]     w_base_addr,
  output logic [$clog2(ARRAY_N):0]  w_num_cols,
  output logic                      mode,
  output logic [2:0]                operation_signal_out,
  output logic                      o_idx_gen_on,
  output logic                      o_ag_o_on,
  output logic                      o_drain,
  output logic [ADDR_WIDTH-1:0]     o_base_addr
);

  localparam int unsigned CW = DIM_WIDTH + 1;
  localparam int unsigned RW = $clog2(ARRAY_N) + 1;

  localparam logic [2:0] OP_IDLE  = 3'b000;
  localparam logic [2:0] OP_CLR   = 3'b001;
  localparam logic [2:0] OP_CALC  = 3'b010;
  localparam logic [2:0] OP_DRAIN = 3'b100;

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TILE_N   = CW'(ARRAY_N);
  localparam logic [CW-1:0] TILE_M   = CW'(ARRAY_M);
  localparam logic [CW-1:0] SKEW_LEN = CW'(ARRAY_N + ARRAY_M - 2);

  typedef enum logic [2:0] {
    StIdle, StClear, StStream, StSkew, StDrain, StNext, StDone
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [DIM_WIDTH-1:0]  k_q, n_q;
  // Remaining rows/cols from the current tile onward; min() against the tile size gives rows/cols.
  logic [CW-1:0]         m_rem_q, n_rem_q;
  logic [ADDR_WIDTH-1:0] w_base_q;
  logic [ADDR_WIDTH-1:0] a_addr_q, w_addr_q, o_addr_q;
  logic                  mode_q, err_q;

  logic [CW-1:0] rows_w, cols_w;
  logic          last_m, last_n, zero_dim, accept, in_tile;

  assign rows_w   = (m_rem_q > TILE_N) ? TILE_N : m_rem_q;
  assign cols_w   = (n_rem_q > TILE_M) ? TILE_M : n_rem_q;
  assign last_m   = (m_rem_q <= TILE_N);
  assign last_n   = (n_rem_q <= TILE_M);
  assign zero_dim = (M == '0) || (K == '0) || (N == '0);
  assign accept   = (state_q == StIdle) && start && !abort;
  assign in_tile  = (state_q != StIdle) && (state_q != StDone);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = zero_dim ? StDone : StClear;
      StClear:  state_d = StStream;
      StStream: if (cnt_q == {1'b0, k_q} - ONE) state_d = (SKEW_LEN == '0) ? StDrain : StSkew;
      StSkew:   if (cnt_q == SKEW_LEN - ONE) state_d = StDrain;
      StDrain:  if (cnt_q == rows_w - ONE) state_d = StNext;
      StNext:   state_d = (last_m && last_n) ? StDone : StClear;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (abort && state_q != StIdle) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      k_q      <= '0;
      n_q      <= '0;
      m_rem_q  <= '0;
      n_rem_q  <= '0;
      w_base_q <= '0;
      a_addr_q <= '0;
      w_addr_q <= '0;
      o_addr_q <= '0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Per-state cycle counter restarts on every state change.
      if (state_d != state_q) cnt_q <= '0;
      else if (in_tile)       cnt_q <= cnt_q + ONE;

      if (accept) begin
        k_q      <= K;
        n_q      <= N;
        m_rem_q  <= {1'b0, M};
        n_rem_q  <= {1'b0, N};
        w_base_q <= w_base;
        a_addr_q <= a_base;
        w_addr_q <= w_base;
        o_addr_q <= o_base;
        mode_q   <= mode_in;
        err_q    <= zero_dim;
      end else if (state_q == StNext) begin
        // Addresses advance by accumulation; wrap modulo 2^ADDR_WIDTH.
        o_addr_q <= o_addr_q + ADDR_WIDTH'(ARRAY_N);
        if (last_n) begin
          n_rem_q  <= {1'b0, n_q};
          m_rem_q  <= m_rem_q - TILE_N;
          a_addr_q <= a_addr_q + ADDR_WIDTH'(k_q);
          w_addr_q <= w_base_q;
        end else begin
          n_rem_q  <= n_rem_q - TILE_M;
          w_addr_q <= w_addr_q + ADDR_WIDTH'(k_q);
        end
      end
    end
  end

  always_comb begin
    busy                 = in_tile;
    done                 = 1'b0;
    err                  = 1'b0;
    a_buf_on             = 1'b0;
    w_buf_on             = 1'b0;
    o_idx_gen_on         = 1'b0;
    o_ag_o_on            = 1'b0;
    o_drain              = 1'b0;
    operation_signal_out = OP_IDLE;
    unique case (state_q)
      StClear:  operation_signal_out = OP_CLR;
      StStream: begin
        operation_signal_out = OP_CALC;
        a_buf_on             = 1'b1;
        w_buf_on             = 1'b1;
        o_idx_gen_on         = 1'b1;
      end
      StSkew: begin
        operation_signal_out = OP_CALC;
        o_idx_gen_on         = 1'b1;
      end
      StDrain: begin
        operation_signal_out = OP_DRAIN;
        o_drain              = 1'b1;
        o_ag_o_on            = 1'b1;
      end
      StDone: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  assign a_num_rows  = in_tile ? rows_w[RW-1:0] : '0;
  assign w_num_cols  = in_tile ? cols_w[RW-1:0] : '0;
  assign a_base_addr = a_addr_q;
  assign w_base_addr = w_addr_q;
  assign o_base_addr = o_addr_q;
  assign mode        = mode_q;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Self-checking bench for systolic_tile_ctrl (8x8 array, 8-bit addresses).
module tb_systolic_tile_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0, abort = 1'b0, mode_in = 1'b0;
  logic [15:0] M = '0, K = '0, N = '0;
  logic [7:0]  a_base = '0, w_base = '0, o_base = '0;
  logic        busy, done, err, a_buf_on, w_buf_on, mode;
  logic [7:0]  a_base_addr, w_base_addr, o_base_addr;
  logic [3:0]  a_num_rows, w_num_cols;
  logic [2:0]  operation_signal_out;
  logic        o_idx_gen_on, o_ag_o_on, o_drain;

  systolic_tile_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode_in(mode_in),
    .M(M), .K(K), .N(N), .a_base(a_base), .w_base(w_base), .o_base(o_base),
    .busy(busy), .done(done), .err(err), .a_buf_on(a_buf_on), .w_buf_on(w_buf_on),
    .a_base_addr(a_base_addr), .a_num_rows(a_num_rows), .w_base_addr(w_base_addr),
    .w_num_cols(w_num_cols), .mode(mode), .operation_signal_out(operation_signal_out),
    .o_idx_gen_on(o_idx_gen_on), .o_ag_o_on(o_ag_o_on), .o_drain(o_drain),
    .o_base_addr(o_base_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int m; int k; int n;
    int ab; int wb; int ob;
    bit md;
    bit exp_err;
    int exp_cyc;  // cycle (start cycle = 0) in which done is high
  } vec_t;

  typedef struct { int rows; int cols; int a; int w; int o; } tile_t;

  vec_t  vecs [9];
  tile_t sb [$];
  int    nchecks = 0;
  int    nerrors = 0;

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Drive one job through the scoreboard and check tile geometry, timing and pulse shape.
  task automatic run_job(input vec_t v, input bit pulse_busy_start);
    int    cyc, nstream, nwbuf, ndrain, exp_stream, exp_drain;
    int    first_stream, first_drain, ntiles, idx, extra_done;
    bit    got_done, busy_bad;
    tile_t t, e;
    idx = 0; exp_stream = 0; exp_drain = 0; ntiles = 0;
    if (v.m != 0 && v.k != 0 && v.n != 0) begin
      for (int tm = 0; tm < (v.m + 7) / 8; tm++) begin
        for (int tn = 0; tn < (v.n + 7) / 8; tn++) begin
          t.rows = min2(8, v.m - tm * 8);
          t.cols = min2(8, v.n - tn * 8);
          t.a    = (v.ab + tm * v.k) % 256;
          t.w    = (v.wb + tn * v.k) % 256;
          t.o    = (v.ob + idx * 8) % 256;
          sb.push_back(t);
          idx++;
          exp_stream += v.k;
          exp_drain  += t.rows;
        end
      end
    end
    ntiles = idx;
    @(negedge clk);
    M = 16'(v.m); K = 16'(v.k); N = 16'(v.n);
    a_base = 8'(v.ab); w_base = 8'(v.wb); o_base = 8'(v.ob);
    mode_in = v.md; start = 1'b1; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    mode_in = ~v.md;
    cyc = 1; got_done = 0; busy_bad = 0;
    nstream = 0; nwbuf = 0; ndrain = 0; first_stream = -1; first_drain = -1;
    while (!got_done && cyc <= v.exp_cyc + 20) begin
      if (operation_signal_out == 3'b001) begin
        if (sb.size() == 0) check("extra_tile", 1, 0);
        else begin
          e = sb.pop_front();
          check("tile_rows", int'(a_num_rows), e.rows);
          check("tile_cols", int'(w_num_cols), e.cols);
          check("tile_a_addr", int'(a_base_addr), e.a);
          check("tile_w_addr", int'(w_base_addr), e.w);
          check("tile_o_addr", int'(o_base_addr), e.o);
        end
      end
      if (a_buf_on) begin nstream++; if (first_stream < 0) first_stream = cyc; end
      if (w_buf_on) nwbuf++;
      if (o_drain)  begin ndrain++;  if (first_drain < 0) first_drain = cyc; end
      if (done) begin
        got_done = 1;
        check("done_cycle", cyc, v.exp_cyc);
        check("err_with_done", int'(err), int'(v.exp_err));
        check("busy_at_done", int'(busy), 0);
        if (!v.exp_err) check("mode_latched", int'(mode), int'(v.md));
      end else if (!busy) busy_bad = 1;
      if (pulse_busy_start && cyc == 5) start = 1'b1;
      if (pulse_busy_start && cyc == 6) start = 1'b0;
      if (!got_done) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!got_done) check("done_timeout", 0, 1);
    check("busy_until_done", int'(busy_bad), 0);
    check("a_buf_cycles", nstream, exp_stream);
    check("w_buf_cycles", nwbuf, exp_stream);
    check("drain_cycles", ndrain, exp_drain);
    check("tiles_left", sb.size(), 0);
    if (ntiles > 0) begin
      check("first_stream_cycle", first_stream, 2);
      check("first_drain_cycle", first_drain, 2 + v.k + 14);
    end
    sb.delete();
    @(negedge clk);
    check("done_pulse_width", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    if (pulse_busy_start) begin
      extra_done = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done || busy) extra_done++;
      end
      check("ignored_busy_start", extra_done, 0);
    end
  endtask

  initial begin
    int cyc;
    bit seen;
    vecs[0] = '{8,   4,   8,  8'h10, 8'h20, 8'h30, 1'b1, 1'b0, 29};
    vecs[1] = '{10,  3,   5,  8'h00, 8'h40, 8'h80, 1'b0, 1'b0, 49};
    vecs[2] = '{17,  2,   9,  8'h05, 8'h50, 8'h90, 1'b1, 1'b0, 143};
    vecs[3] = '{5,   0,   3,  8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 1};
    vecs[4] = '{3,   2,   0,  8'h01, 8'h02, 8'h03, 1'b1, 1'b1, 1};
    vecs[5] = '{0,   1,   1,  8'h01, 8'h02, 8'h03, 1'b0, 1'b1, 1};
    vecs[6] = '{1,   1,   1,  8'h7f, 8'h7e, 8'h7d, 1'b1, 1'b0, 19};
    vecs[7] = '{16,  5,   16, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 117};
    vecs[8] = '{20,  100, 3,  8'd200, 8'd250, 8'd240, 1'b1, 1'b0, 369};

    // Reset state
    #3;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_op", int'(operation_signal_out), 0);
    check("rst_a_addr", int'(a_base_addr), 0);
    check("rst_rows", int'(a_num_rows), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) run_job(vecs[i], 1'b0);

    // Abort mid-STREAM, then a new job two cycles later.
    @(negedge clk);
    M = 16'd8; K = 16'd4; N = 16'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_pre_stream", int'(a_buf_on), 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_op", int'(operation_signal_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_a_buf", int'(a_buf_on), 0);
    check("abort_no_done", int'(done), 0);
    @(negedge clk);
    check("abort_no_done2", int'(done), 0);
    run_job(vecs[0], 1'b0);

    // start and abort together in IDLE: abort wins.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", int'(busy), 0);
    check("abort_start_op", int'(operation_signal_out), 0);

    // Asynchronous reset during DRAIN.
    @(negedge clk);
    M = 16'd8; K = 16'd4; N = 16'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    cyc = 0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (o_drain) seen = 1;
    end
    check("reach_drain", int'(seen), 1);
    #2 reset = 1'b0;
    #1;
    check("arst_drain", int'(o_drain), 0);
    check("arst_ag", int'(o_ag_o_on), 0);
    check("arst_op", int'(operation_signal_out), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_o_addr", int'(o_base_addr), 0);
    check("arst_mode", int'(mode), 0);
    @(negedge clk);
    reset = 1'b1;
    run_job(vecs[1], 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
